// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Pipeline fetch stage. Holds the program counter, selects the
//            next PC from prioritized redirects/stall, and loads the IF/ID
//            pipeline register (instruction, PC+4, valid) for decode.
//            Also counts every valid instruction handed to decode.
// Ports    :
//   clk          in   1   single clock, rising edge
//   reset        in   1   synchronous active-high reset
//   imem_addr    out  32  fetch address (current PC)
//   imem_instr   in   32  instruction word for imem_addr (same cycle)
//   stall        in   1   hold PC and IF/ID
//   flush        in   1   load bubble into IF/ID
//   exc          in   1   redirect to EXC_PC
//   br_taken/br_target   in 1/32  taken-branch redirect
//   jr/jr_target         in 1/32  register-jump redirect
//   jmp/jmp_target       in 1/32  direct-jump redirect
//   if_id_instr  out  32  registered instruction
//   if_id_pc4    out  32  registered PC+4 of that instruction
//   if_id_valid  out  1   1 = real instruction, 0 = bubble
//   fetch_count  out  32  number of valid loads into IF/ID
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        exc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] c_nop      = 32'h0000_0000;
  localparam logic [31:0] c_align    = 32'hFFFF_FFFC;

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc4;
  logic        r_if_id_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc4;
  logic        w_redirect;
  logic [31:0] w_target;

  // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
  assign w_pc4      = r_pc + 32'd4;
  assign w_redirect = exc | br_taken | jr | jmp;

  // Redirect target in priority order; lower-priority targets are ignored.
  always_comb begin
    w_target = jmp_target;
    if (exc)           w_target = EXC_PC;
    else if (br_taken) w_target = br_target;
    else if (jr)       w_target = jr_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_if_id_instr <= c_nop;
      r_if_id_pc4   <= 32'h0;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= 32'h0;
    end else if (w_redirect) begin
      // Redirect wins over stall and always squashes the wrong-path fetch.
      r_pc          <= w_target & c_align;
      r_if_id_instr <= c_nop;
      r_if_id_pc4   <= 32'h0;
      r_if_id_valid <= 1'b0;
    end else begin
      if (!stall) begin
        r_pc <= w_pc4;
      end
      if (flush) begin
        r_if_id_instr <= c_nop;
        r_if_id_pc4   <= 32'h0;
        r_if_id_valid <= 1'b0;
      end else if (!stall) begin
        r_if_id_instr <= imem_instr;
        r_if_id_pc4   <= w_pc4;
        r_if_id_valid <= 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
